l2_request_arbiter: RTL and testbench



---
 rtl/l2_request_arbiter_if.sv | 26 ++
 rtl/l2_request_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_request_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_request_arbiter_if.sv
// Request/response channel between an L1 requester and the L2 side.
// The address path carries a word address from master to slave, and the
// data path carries a single-beat response back from slave to master.
interface l2_chan_if #(
    parameter int AW = 30,
    parameter int DW = 32
) ();
    logic          addr_valid;
    logic [AW-1:0] addr;
    logic          addr_ready;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          data_ready;

    // Issues requests and consumes responses.
    modport master (
        output addr_valid, addr, data_ready,
        input  addr_ready, data_valid, data
    );

    // Accepts requests and produces responses.
    modport slave (
        input  addr_valid, addr, data_ready,
        output addr_ready, data_valid, data
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// Shares the single L1-to-L2 channel between the instruction cache and the
// data cache. It accepts one request at a time, choosing between the two
// requesters round-robin. It forwards the request to L2, captures the
// single-beat response and returns it to the requester that issued it.
module l2_request_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int L2_BUS_WIDTH  = 32
) (
    input  logic      CLK,
    input  logic      RST_N,
    l2_chan_if.slave  ins_bus,
    l2_chan_if.slave  dat_bus,
    l2_chan_if.master l2_bus,
    output logic      ARB_BUSY,
    output logic      ARB_OWNER
);
    localparam int WA = ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;   // 0 = INS, 1 = DAT
    logic                    prio_q,  prio_d;    // 0 = INS preferred
    logic [WA-1:0]           addr_q,  addr_d;
    logic [L2_BUS_WIDTH-1:0] data_q,  data_d;

    logic grant_dat;
    logic win_valid;
    logic ins_addr_ready;
    logic dat_addr_ready;
    logic owner_resp_ready;

    // DAT wins when it is the only requester or when the tie goes its way.
    assign grant_dat = dat_bus.addr_valid & (~ins_bus.addr_valid | prio_q);
    assign win_valid = ins_bus.addr_valid | dat_bus.addr_valid;

    // The response is consumed only by the requester that owns the transaction.
    assign owner_resp_ready = owner_q ? dat_bus.data_ready : ins_bus.data_ready;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and the requester-ready decode.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        prio_d         = prio_q;
        addr_d         = addr_q;
        data_d         = data_q;
        ins_addr_ready = 1'b0;
        dat_addr_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Readies are forced low during reset, even though the
                // state register already reads IDLE.
                ins_addr_ready = RST_N & ins_bus.addr_valid & ~grant_dat;
                dat_addr_ready = RST_N & grant_dat;
                if (win_valid) begin
                    addr_d  = grant_dat ? dat_bus.addr : ins_bus.addr;
                    owner_d = grant_dat;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (l2_bus.addr_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (l2_bus.data_valid) begin
                    data_d  = l2_bus.data;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (owner_resp_ready) begin
                    prio_d  = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ins_bus.addr_ready = ins_addr_ready;
    assign dat_bus.addr_ready = dat_addr_ready;

    // Handshake outputs toward L2 decode purely from the state register.
    assign l2_bus.addr_valid  = (state_q == ST_ISSUE);
    assign l2_bus.addr        = addr_q;
    assign l2_bus.data_ready  = (state_q == ST_WAIT);

    // Both requesters always see the captured data; only the valid is steered.
    assign ins_bus.data_valid = (state_q == ST_RETURN) & ~owner_q;
    assign dat_bus.data_valid = (state_q == ST_RETURN) &  owner_q;
    assign ins_bus.data       = data_q;
    assign dat_bus.data       = data_q;

    assign ARB_BUSY  = (state_q != ST_IDLE);
    assign ARB_OWNER = owner_q;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboard bench for l2_request_arbiter: directed requests push expected
// L2 addresses and responses into queues; monitors pop and compare them.
module tb_l2_request_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    l2_chan_if #(.AW(30), .DW(32)) ins_bus ();
    l2_chan_if #(.AW(30), .DW(32)) dat_bus ();
    l2_chan_if #(.AW(30), .DW(32)) l2_bus ();
    logic arb_busy;
    logic arb_owner;

    l2_request_arbiter #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .ins_bus  (ins_bus),
        .dat_bus  (dat_bus),
        .l2_bus   (l2_bus),
        .ARB_BUSY (arb_busy),
        .ARB_OWNER(arb_owner)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit mon_en    = 1'b0;
    bit rand_mode = 1'b0;
    int addr_stall     = 0;
    int resp_delay     = 0;
    int ins_resp_stall = 0;
    int addr_stall_seen = 0;
    int resp_stall_seen = 0;
    int req_hs_cnt   = 0;
    int ins_req_cyc  = -1;
    int ins_resp_cyc = -1;
    int dat_req_cyc  = -1;

    logic [30:0] exp_addr_q[$];   // {owner, addr}
    logic [32:0] exp_resp_q[$];   // {owner, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] l2_lookup(input logic [29:0] a);
        case (a)
            30'h10:  l2_lookup = 32'h0000_0013;
            30'h200: l2_lookup = 32'hDA7A_0200;
            30'h20:  l2_lookup = 32'h0000_0021;
            default: l2_lookup = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Requester-side monitor: counts grants and checks ready gating.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ins_bus.addr_valid && ins_bus.addr_ready) begin
                req_hs_cnt++;
                ins_req_cyc = cyc;
                $display("GRANT ins addr=%h cyc=%0d", ins_bus.addr, cyc);
            end
            if (dat_bus.addr_valid && dat_bus.addr_ready) begin
                req_hs_cnt++;
                dat_req_cyc = cyc;
                $display("GRANT dat addr=%h cyc=%0d", dat_bus.addr, cyc);
            end
            if (arb_busy)
                check("ready_while_busy", {ins_bus.addr_ready, dat_bus.addr_ready}, 0);
        end
    end

    // L2 request monitor.
    always @(negedge clk) begin
        if (mon_en && rst_n && l2_bus.addr_valid && l2_bus.addr_ready) begin
            $display("L2 REQ addr=%h owner=%0d", l2_bus.addr, arb_owner);
            check("unexpected_l2_req", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0)
                check("l2_req_owner_addr", {arb_owner, l2_bus.addr}, exp_addr_q.pop_front());
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ins_bus.data_valid && ins_bus.data_ready) begin
                ins_resp_cyc = cyc;
                $display("RESP ins data=%h cyc=%0d", ins_bus.data, cyc);
                check("unexpected_resp_ins", exp_resp_q.size() != 0, 1);
                if (exp_resp_q.size() != 0)
                    check("resp_ins", {1'b0, ins_bus.data}, exp_resp_q.pop_front());
            end
            if (dat_bus.data_valid && dat_bus.data_ready) begin
                $display("RESP dat data=%h cyc=%0d", dat_bus.data, cyc);
                check("unexpected_resp_dat", exp_resp_q.size() != 0, 1);
                if (exp_resp_q.size() != 0)
                    check("resp_dat", {1'b1, dat_bus.data}, exp_resp_q.pop_front());
            end
        end
    end

    // Stall monitor: held outputs must not move while the far side stalls.
    logic        prev_a_stall = 1'b0;
    logic [29:0] prev_a;
    logic        prev_r_stall = 1'b0;
    logic [33:0] prev_r;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_a_stall = 1'b0;
            prev_r_stall = 1'b0;
        end else begin
            if (prev_a_stall)
                check("addr_hold", {l2_bus.addr_valid, l2_bus.addr}, {1'b1, prev_a});
            prev_a_stall = l2_bus.addr_valid && !l2_bus.addr_ready;
            prev_a       = l2_bus.addr;
            if (prev_a_stall) addr_stall_seen++;
            if (prev_r_stall)
                check("resp_hold", {ins_bus.data_valid, dat_bus.data_valid,
                                    arb_owner ? dat_bus.data : ins_bus.data}, prev_r);
            prev_r_stall = (ins_bus.data_valid && !ins_bus.data_ready) ||
                           (dat_bus.data_valid && !dat_bus.data_ready);
            prev_r       = {ins_bus.data_valid, dat_bus.data_valid,
                            arb_owner ? dat_bus.data : ins_bus.data};
            if (prev_r_stall) resp_stall_seen++;
        end
    end

    // L2 responder model with address stall and response delay knobs.
    initial begin
        bit          take_a;
        bit          take_d;
        logic [29:0] a_s;
        bit          pend;
        int          cnt;
        logic [31:0] pdata;
        pend  = 1'b0;
        cnt   = 0;
        pdata = '0;
        l2_bus.addr_ready = 1'b1;
        l2_bus.data_valid = 1'b0;
        l2_bus.data       = '0;
        forever begin
            @(negedge clk);
            take_a = l2_bus.addr_valid && l2_bus.addr_ready;
            take_d = l2_bus.data_valid && l2_bus.data_ready;
            a_s    = l2_bus.addr;
            @(posedge clk);
            #1;
            if (rand_mode) begin
                l2_bus.addr_ready = 1'($urandom);
                l2_bus.data_valid = 1'($urandom);
                l2_bus.data       = $urandom;
                pend = 1'b0;
            end else if (!rst_n) begin
                pend = 1'b0;
                l2_bus.data_valid = 1'b0;
                l2_bus.addr_ready = 1'b1;
            end else begin
                if (take_d) l2_bus.data_valid = 1'b0;
                if (take_a) begin
                    pend  = 1'b1;
                    cnt   = resp_delay;
                    pdata = l2_lookup(a_s);
                end
                if (pend) begin
                    if (cnt == 0) begin
                        l2_bus.data_valid = 1'b1;
                        l2_bus.data       = pdata;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (l2_bus.addr_valid && addr_stall > 0) begin
                    l2_bus.addr_ready = 1'b0;
                    addr_stall--;
                end else begin
                    l2_bus.addr_ready = 1'b1;
                end
            end
        end
    end

    // Requester response-ready driver.
    initial begin
        ins_bus.data_ready = 1'b1;
        dat_bus.data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                ins_bus.data_ready = 1'($urandom);
                dat_bus.data_ready = 1'($urandom);
            end else begin
                if (ins_bus.data_valid && ins_resp_stall > 0) begin
                    ins_bus.data_ready = 1'b0;
                    ins_resp_stall--;
                end else begin
                    ins_bus.data_ready = 1'b1;
                end
                dat_bus.data_ready = 1'b1;
            end
        end
    end

    task automatic start_req(input bit is_dat, input logic [29:0] a);
        if (is_dat) begin
            dat_bus.addr_valid = 1'b1;
            dat_bus.addr       = a;
        end else begin
            ins_bus.addr_valid = 1'b1;
            ins_bus.addr       = a;
        end
    endtask

    task automatic wait_grants(input int n, input string name);
        int n0 = req_hs_cnt;
        int i  = 0;
        while (req_hs_cnt < n0 + n && i < 400) begin
            @(posedge clk);
            i++;
        end
        #1;
        ins_bus.addr_valid = 1'b0;
        dat_bus.addr_valid = 1'b0;
        check({name, "_grants"}, req_hs_cnt - n0, n);
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((exp_addr_q.size() != 0 || exp_resp_q.size() != 0 || arb_busy) && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        check({name, "_drain"}, exp_addr_q.size() + exp_resp_q.size(), 0);
        check({name, "_idle"}, arb_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_bus.addr_valid = 1'b0;
        ins_bus.addr       = '0;
        dat_bus.addr_valid = 1'b0;
        dat_bus.addr       = '0;

        // Reset with random inputs: every output must read zero.
        #2;
        rst_n     = 1'b0;
        rand_mode = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            ins_bus.addr_valid = 1'($urandom);
            ins_bus.addr       = 30'($urandom);
            dat_bus.addr_valid = 1'($urandom);
            dat_bus.addr       = 30'($urandom);
            @(negedge clk);
            check("reset_outputs_zero",
                  {ins_bus.addr_ready, ins_bus.data_valid, |ins_bus.data,
                   dat_bus.addr_ready, dat_bus.data_valid, |dat_bus.data,
                   l2_bus.addr_valid, |l2_bus.addr, l2_bus.data_ready,
                   arb_busy, arb_owner}, 0);
        end
        rand_mode = 1'b0;
        ins_bus.addr_valid = 1'b0;
        dat_bus.addr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_busy", arb_busy, 0);
        mon_en = 1'b1;

        // Both requesters continuously valid: INS first, then alternating.
        exp_addr_q.push_back({1'b0, 30'h10});
        exp_addr_q.push_back({1'b1, 30'h200});
        exp_addr_q.push_back({1'b0, 30'h10});
        exp_resp_q.push_back({1'b0, 32'h0000_0013});
        exp_resp_q.push_back({1'b1, 32'hDA7A_0200});
        exp_resp_q.push_back({1'b0, 32'h0000_0013});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h10);
        start_req(1'b1, 30'h200);
        wait_grants(3, "both");
        drain("both");

        // Single INS request at minimum latency.
        exp_addr_q.push_back({1'b0, 30'h10});
        exp_resp_q.push_back({1'b0, 32'h0000_0013});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h10);
        wait_grants(1, "single");
        drain("single");
        check("single_latency", ins_resp_cyc - ins_req_cyc, 3);

        // DAT arrives during an INS transaction and waits its turn.
        exp_addr_q.push_back({1'b0, 30'h10});
        exp_addr_q.push_back({1'b1, 30'h200});
        exp_resp_q.push_back({1'b0, 32'h0000_0013});
        exp_resp_q.push_back({1'b1, 32'hDA7A_0200});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h10);
        wait_grants(1, "mid_ins");
        start_req(1'b1, 30'h200);
        wait_grants(1, "mid_dat");
        drain("mid");
        check("mid_dat_accept_gap", dat_req_cyc - ins_resp_cyc, 1);

        // Back-pressure on both the L2 address and the INS response.
        addr_stall_seen = 0;
        resp_stall_seen = 0;
        addr_stall      = 5;
        ins_resp_stall  = 3;
        exp_addr_q.push_back({1'b0, 30'h10});
        exp_resp_q.push_back({1'b0, 32'h0000_0013});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h10);
        wait_grants(1, "bp");
        drain("bp");
        check("bp_addr_stalls", addr_stall_seen, 5);
        check("bp_resp_stalls", resp_stall_seen, 3);
        check("bp_latency", ins_resp_cyc - ins_req_cyc, 11);

        // Reset while waiting for L2: no response may be delivered.
        resp_delay = 1000;
        exp_addr_q.push_back({1'b0, 30'h10});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h10);
        wait_grants(1, "rstwait");
        begin
            int i = 0;
            while (!l2_bus.data_ready && i < 50) begin
                @(negedge clk);
                i++;
            end
            check("rstwait_reached_wait", l2_bus.data_ready, 1);
        end
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n      = 1'b1;
        resp_delay = 0;
        @(negedge clk);
        #1;
        check("rstwait_idle", {arb_busy, arb_owner, l2_bus.data_ready}, 0);
        check("rstwait_addr_consumed", exp_addr_q.size(), 0);
        repeat (10) @(negedge clk);
        check("rstwait_no_resp", {ins_bus.data_valid, dat_bus.data_valid, arb_busy}, 0);

        // A fresh INS request completes normally after the abort.
        exp_addr_q.push_back({1'b0, 30'h20});
        exp_resp_q.push_back({1'b0, 32'h0000_0021});
        @(posedge clk);
        #1;
        start_req(1'b0, 30'h20);
        wait_grants(1, "post_rst");
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
